// File: rtl/ram_to_notes.sv
// Playback reader for the player-piano song RAM: fetches one 48-key frame per beat
// as three 16-bit words and presents it on notes as a single atomic update.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | not in playback; outputs and frame index held at zero
// WAIT    | playback active, waiting for the next unpaused beat
// FETCH0  | read word 3*frame+0 (notes[47:32])
// FETCH1  | read word 3*frame+1, capture word 0
// FETCH2  | read word 3*frame+2, capture word 1
// COMMIT  | capture word 2, publish the full frame, advance frame
// DONE    | song ended; notes cleared until playback is left
module ram_to_notes #(
   parameter int MAX_BEATS = 42
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        beat,
   input  logic [1:0]  master_state,
   input  logic [7:0]  switches,
   input  logic [6:0]  record_length,
   input  logic [15:0] read_data,
   output logic [6:0]  read_address,
   output logic        read_enable,
   output logic [47:0] notes,
   output logic        start_playback,
   output logic        finished_playback
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_FETCH0, S_FETCH1, S_FETCH2, S_COMMIT, S_DONE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_frame;
   logic [6:0]  r_read_address;
   logic        r_read_enable;
   logic [47:0] r_shadow;
   logic [47:0] r_notes;
   logic        r_start;
   logic        r_finish;

   logic        w_play, w_abort, w_go, w_in_song, w_loop_ok;
   logic        w_start, w_finish, w_fetch, w_wrap;
   logic [6:0]  w_len_clamped;
   logic [5:0]  w_frame_sel;
   logic [6:0]  w_base;

   assign w_play        = (master_state == 2'b10);
   assign w_abort       = (r_state != S_IDLE) && !w_play;
   assign w_go          = beat && !switches[7];
   assign w_len_clamped = (record_length > 7'(MAX_BEATS)) ? 7'(MAX_BEATS) : record_length;
   assign w_in_song     = ({1'b0, r_frame} < w_len_clamped);
   assign w_loop_ok     = switches[0] && (w_len_clamped != 7'd0);
   assign w_frame_sel   = w_wrap ? 6'd0 : r_frame;
   // 3*frame without a multiplier; max 3*41 = 123 fits in 7 bits
   assign w_base        = {w_frame_sel, 1'b0} + {1'b0, w_frame_sel};

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_finish    = 1'b0;
      w_fetch     = 1'b0;
      w_wrap      = 1'b0;
      if (w_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_play) begin
                  w_state_nxt = S_WAIT;
                  w_start     = 1'b1;
               end
            end
            S_WAIT: begin
               if (w_go) begin
                  if (w_in_song) begin
                     w_state_nxt = S_FETCH0;
                     w_fetch     = 1'b1;
                  end else if (w_loop_ok) begin
                     w_state_nxt = S_FETCH0;
                     w_fetch     = 1'b1;
                     w_wrap      = 1'b1;
                  end else begin
                     w_state_nxt = S_DONE;
                     w_finish    = 1'b1;
                  end
               end
            end
            S_FETCH0: w_state_nxt = S_FETCH1;
            S_FETCH1: w_state_nxt = S_FETCH2;
            S_FETCH2: w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_WAIT;
            S_DONE:   w_state_nxt = S_DONE;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_frame        <= 6'd0;
         r_read_address <= 7'd0;
         r_read_enable  <= 1'b0;
         r_shadow       <= 48'd0;
         r_notes        <= 48'd0;
         r_start        <= 1'b0;
         r_finish       <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_start  <= w_start;
         r_finish <= w_finish;
         if (w_abort || (r_state == S_IDLE)) begin
            r_frame        <= 6'd0;
            r_read_address <= 7'd0;
            r_read_enable  <= 1'b0;
            r_shadow       <= 48'd0;
            r_notes        <= 48'd0;
         end else begin
            case (r_state)
               S_WAIT: begin
                  if (w_fetch) begin
                     r_frame        <= w_frame_sel;
                     r_read_address <= w_base;
                     r_read_enable  <= 1'b1;
                  end
                  if (w_finish) r_notes <= 48'd0;
               end
               S_FETCH0: r_read_address <= r_read_address + 7'd1;
               S_FETCH1: begin
                  r_read_address  <= r_read_address + 7'd1;
                  r_shadow[47:32] <= read_data;
               end
               S_FETCH2: begin
                  r_read_enable   <= 1'b0;
                  r_shadow[31:16] <= read_data;
               end
               S_COMMIT: begin
                  // whole frame lands on one edge so key drivers never see a mix
                  r_shadow[15:0] <= read_data;
                  r_notes        <= {r_shadow[47:16], read_data};
                  r_frame        <= r_frame + 6'd1;
               end
               default: r_notes <= r_notes;
            endcase
         end
      end
   end

   assign read_address      = r_read_address;
   assign read_enable       = r_read_enable;
   assign notes             = r_notes;
   assign start_playback    = r_start;
   assign finished_playback = r_finish;

endmodule

// File: tb/tb_ram_to_notes.sv
// Directed bench for ram_to_notes: synchronous RAM model, read-address log and
// pulse counters, one task per scenario.
module tb_ram_to_notes;

   logic        clk;
   logic        reset;
   logic        beat;
   logic [1:0]  master_state;
   logic [7:0]  switches;
   logic [6:0]  record_length;
   logic [15:0] read_data;
   logic [6:0]  read_address;
   logic        read_enable;
   logic [47:0] notes;
   logic        start_playback;
   logic        finished_playback;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [128];
   logic [6:0]  rd_log [$];
   int          fin_cnt = 0;
   logic [47:0] last_notes;

   ram_to_notes #(.MAX_BEATS(42)) dut (
      .clk               (clk),
      .reset             (reset),
      .beat              (beat),
      .master_state      (master_state),
      .switches          (switches),
      .record_length     (record_length),
      .read_data         (read_data),
      .read_address      (read_address),
      .read_enable       (read_enable),
      .notes             (notes),
      .start_playback    (start_playback),
      .finished_playback (finished_playback)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (read_enable) begin
         read_data <= mem[read_address];
         rd_log.push_back(read_address);
      end
      if (finished_playback) fin_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_beat();
      beat = 1'b1;
      @(posedge clk);
      #1;
      beat = 1'b0;
   endtask

   task automatic enter_play();
      master_state = 2'b10;
      cyc(1);
      checks++;
      if (start_playback !== 1'b1) begin
         errors++;
         $display("FAIL start_pulse got %b want 1", start_playback);
      end
      cyc(1);
      checks++;
      if (start_playback !== 1'b0) begin
         errors++;
         $display("FAIL start_width got %b want 0", start_playback);
      end
   endtask

   task automatic leave_play();
      master_state = 2'b00;
      cyc(2);
   endtask

   task automatic fetch_check(input int k, input string nm);
      logic [47:0] exp;
      int base;
      exp  = {mem[3*k], mem[3*k+1], mem[3*k+2]};
      base = rd_log.size();
      do_beat();
      cyc(3);
      checks++;
      if (notes !== last_notes) begin
         errors++;
         $display("FAIL %s_hold frame %0d got %h want %h", nm, k, notes, last_notes);
      end
      cyc(1);
      checks++;
      if (notes !== exp) begin
         errors++;
         $display("FAIL %s_notes frame %0d got %h want %h", nm, k, notes, exp);
      end
      checks++;
      if (rd_log.size() - base !== 3) begin
         errors++;
         $display("FAIL %s_nreads frame %0d got %0d want 3", nm, k, rd_log.size() - base);
      end else begin
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (rd_log[base+j] !== 7'(3*k+j)) begin
               errors++;
               $display("FAIL %s_addr frame %0d got %0d want %0d", nm, k, rd_log[base+j], 3*k+j);
            end
         end
      end
      last_notes = exp;
   endtask

   task automatic test_reset();
      int base;
      checks++;
      if ({notes, read_address, read_enable, start_playback, finished_playback} !== 59'd0) begin
         errors++;
         $display("FAIL reset_initial got %h/%0d/%b want all zero", notes, read_address, read_enable);
      end
      reset = 1'b1;
      record_length = 7'd3;
      cyc(1);
      enter_play();
      do_beat();
      cyc(1);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (read_enable !== 1'b0 || read_address !== 7'd0) begin
         errors++;
         $display("FAIL reset_async got en=%b addr=%0d want 0/0", read_enable, read_address);
      end
      checks++;
      if (notes !== 48'd0 || start_playback !== 1'b0 || finished_playback !== 1'b0) begin
         errors++;
         $display("FAIL reset_async_out got notes=%h st=%b fin=%b want zero", notes, start_playback, finished_playback);
      end
      master_state = 2'b00;
      #3 reset = 1'b1;
      cyc(1);
      base = rd_log.size();
      for (int i = 0; i < 4; i++) begin
         do_beat();
         cyc(4);
      end
      checks++;
      if (rd_log.size() !== base) begin
         errors++;
         $display("FAIL idle_reads got %0d want 0", rd_log.size() - base);
      end
      checks++;
      if (notes !== 48'd0 || start_playback !== 1'b0 || read_enable !== 1'b0) begin
         errors++;
         $display("FAIL idle_outputs got notes=%h st=%b en=%b want zero", notes, start_playback, read_enable);
      end
   endtask

   task automatic test_single_frame();
      int base, fb;
      mem[0] = 16'hF0F0;
      mem[1] = 16'h0F0F;
      mem[2] = 16'hAAAA;
      record_length = 7'd1;
      switches = 8'h00;
      enter_play();
      last_notes = 48'd0;
      fetch_check(0, "single");
      checks++;
      if (notes !== 48'hF0F00F0FAAAA) begin
         errors++;
         $display("FAIL single_literal got %h want f0f00f0faaaa", notes);
      end
      base = rd_log.size();
      fb = fin_cnt;
      do_beat();
      checks++;
      if (finished_playback !== 1'b1 || notes !== 48'd0) begin
         errors++;
         $display("FAIL single_finish got fin=%b notes=%h want 1/0", finished_playback, notes);
      end
      cyc(3);
      checks++;
      if (fin_cnt - fb !== 1 || rd_log.size() !== base) begin
         errors++;
         $display("FAIL single_finish_once got pulses=%0d reads=%0d want 1/0", fin_cnt - fb, rd_log.size() - base);
      end
      leave_play();
   endtask

   task automatic test_loop();
      int fb;
      record_length = 7'd3;
      switches = 8'h01;
      enter_play();
      fb = fin_cnt;
      last_notes = 48'd0;
      for (int i = 0; i < 7; i++) fetch_check(i % 3, "loop");
      checks++;
      if (fin_cnt !== fb) begin
         errors++;
         $display("FAIL loop_no_finish got %0d want 0", fin_cnt - fb);
      end
      leave_play();
   endtask

   task automatic test_pause();
      int base;
      record_length = 7'd3;
      switches = 8'h00;
      enter_play();
      last_notes = 48'd0;
      fetch_check(0, "pause_pre");
      switches = 8'h80;
      base = rd_log.size();
      for (int i = 0; i < 3; i++) begin
         do_beat();
         cyc(4);
      end
      checks++;
      if (notes !== last_notes || rd_log.size() !== base) begin
         errors++;
         $display("FAIL pause_hold got notes=%h reads=%0d want %h/0", notes, rd_log.size() - base, last_notes);
      end
      switches = 8'h00;
      fetch_check(1, "pause_post");
      leave_play();
   endtask

   task automatic test_abort();
      int fb;
      record_length = 7'd3;
      switches = 8'h00;
      enter_play();
      last_notes = 48'd0;
      fetch_check(0, "abort_pre");
      fb = fin_cnt;
      do_beat();
      cyc(2);
      master_state = 2'b01;
      cyc(1);
      checks++;
      if (notes !== 48'd0 || read_enable !== 1'b0) begin
         errors++;
         $display("FAIL abort_clear got notes=%h en=%b want 0/0", notes, read_enable);
      end
      enter_play();
      checks++;
      if (fin_cnt !== fb) begin
         errors++;
         $display("FAIL abort_no_finish got %0d want 0", fin_cnt - fb);
      end
      last_notes = 48'd0;
      fetch_check(0, "abort_restart");
      leave_play();
   endtask

   task automatic test_edges();
      int base, fb;
      record_length = 7'd0;
      switches = 8'h00;
      enter_play();
      base = rd_log.size();
      fb = fin_cnt;
      do_beat();
      checks++;
      if (finished_playback !== 1'b1) begin
         errors++;
         $display("FAIL len0_finish got %b want 1", finished_playback);
      end
      cyc(3);
      checks++;
      if (rd_log.size() !== base || fin_cnt - fb !== 1) begin
         errors++;
         $display("FAIL len0_reads got reads=%0d pulses=%0d want 0/1", rd_log.size() - base, fin_cnt - fb);
      end
      leave_play();
      record_length = 7'd100;
      enter_play();
      last_notes = 48'd0;
      for (int i = 0; i < 42; i++) fetch_check(i, "clamp");
      checks++;
      if (rd_log[rd_log.size()-1] !== 7'd125) begin
         errors++;
         $display("FAIL clamp_last_addr got %0d want 125", rd_log[rd_log.size()-1]);
      end
      base = rd_log.size();
      do_beat();
      checks++;
      if (finished_playback !== 1'b1 || notes !== 48'd0) begin
         errors++;
         $display("FAIL clamp_finish got fin=%b notes=%h want 1/0", finished_playback, notes);
      end
      cyc(2);
      checks++;
      if (rd_log.size() !== base) begin
         errors++;
         $display("FAIL clamp_extra_reads got %0d want 0", rd_log.size() - base);
      end
      leave_play();
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'(16'h1357 + i * 16'h0203);
      read_data     = 16'd0;
      reset         = 1'b0;
      beat          = 1'b0;
      master_state  = 2'b00;
      switches      = 8'h00;
      record_length = 7'd0;
      last_notes    = 48'd0;
      cyc(2);
      test_reset();
      test_single_frame();
      test_loop();
      test_pause();
      test_abort();
      test_edges();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
